// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
//   Successive-approximation search controller for a WIDTH-bit magnitude
//   comparator. Each SEARCH cycle it presents a trial value on the comparator
//   b operand, samples the equal/greater/lower flags (a = unknown target) and
//   refines the trial one bit at a time, MSB first.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a search (honoured in IDLE or DONE only)
//   cmp_equal    comparator flag: target == trial
//   cmp_greater  comparator flag: target >  trial
//   cmp_lower    comparator flag: target <  trial
//   trial        value driven to comparator b
//   busy         high while searching
//   done         one-cycle pulse when a search terminates
//   result       found value, held until the next accepted start
//   steps        comparisons used by the last search
//   err          last search aborted on an illegal flag combination
module sar_search_ctrl #(
    parameter  int WIDTH = 3,
    localparam int SW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    input  logic             cmp_lower,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [SW-1:0]    steps,
    output logic             err
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [KW-1:0]    k, k_n;
    logic [WIDTH-1:0] trial_n, result_n;
    logic [SW-1:0]    steps_n;
    logic             busy_n, done_n, err_n;
    logic             term;
    logic [WIDTH-1:0] bit_k, bit_lo;

    // Mask of the bit under test and of the next lower bit to be tried.
    assign bit_k  = WIDTH'(1) << k;
    assign bit_lo = bit_k >> 1;

    always_comb begin
        state_n  = state;
        trial_n  = trial;
        k_n      = k;
        steps_n  = steps;
        result_n = result;
        busy_n   = busy;
        err_n    = err;
        done_n   = 1'b0;
        term     = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SEARCH;
                    trial_n = WIDTH'(1) << (WIDTH - 1);
                    k_n     = KW'(WIDTH - 1);
                    steps_n = '0;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            SEARCH: begin
                steps_n = steps + SW'(1);
                case ({cmp_equal, cmp_greater, cmp_lower})
                    3'b100: begin
                        result_n = trial;
                        term     = 1'b1;
                    end
                    3'b010: begin
                        if (k != '0) begin
                            trial_n = trial | bit_lo;
                            k_n     = k - KW'(1);
                        end else begin
                            result_n = trial;
                            term     = 1'b1;
                        end
                    end
                    3'b001: begin
                        if (k != '0) begin
                            trial_n = (trial & ~bit_k) | bit_lo;
                            k_n     = k - KW'(1);
                        end else begin
                            // Trial still has bit 0 set; the target is one below it.
                            result_n = trial & ~WIDTH'(1);
                            term     = 1'b1;
                        end
                    end
                    default: begin
                        err_n    = 1'b1;
                        result_n = trial;
                        term     = 1'b1;
                    end
                endcase
                if (term) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            trial  <= '0;
            k      <= '0;
            steps  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            trial  <= trial_n;
            k      <= k_n;
            steps  <= steps_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
module tb_sar_search_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] target = 3'd0;
    logic       force_none = 1'b0;
    logic       cmp_equal, cmp_greater, cmp_lower;
    logic [2:0] trial, result;
    logic [1:0] steps;
    logic       busy, done, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural comparator: a = target, b = trial; override drops all flags.
    assign cmp_equal   = !force_none && (target == trial);
    assign cmp_greater = !force_none && (target >  trial);
    assign cmp_lower   = !force_none && (target <  trial);

    sar_search_ctrl #(.WIDTH(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmp_equal(cmp_equal), .cmp_greater(cmp_greater), .cmp_lower(cmp_lower),
        .trial(trial), .busy(busy), .done(done),
        .result(result), .steps(steps), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a search for tgt and return cycles from start assertion to done (99 = timeout).
    task automatic do_search(input logic [2:0] tgt, output int lat);
        target = tgt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        if (!done) lat = 99;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (trial  !== 3'd0) begin bad++; $display("FAIL reset_trial got=%0d want=0", trial); end
        total++; if (result !== 3'd0) begin bad++; $display("FAIL reset_result got=%0d want=0", result); end
        total++; if (steps  !== 2'd0) begin bad++; $display("FAIL reset_steps got=%0d want=0", steps); end
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, err}); end
    endtask

    task automatic test_t1_target5();
        target = 3'd5;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        total++; if (trial !== 3'd4 || busy !== 1'b1) begin bad++; $display("FAIL t1_trial0 got=%0d/%b want=4/1", trial, busy); end
        tick();
        total++; if (trial !== 3'd6) begin bad++; $display("FAIL t1_trial1 got=%0d want=6", trial); end
        tick();
        total++; if (trial !== 3'd5 || done !== 1'b0) begin bad++; $display("FAIL t1_trial2 got=%0d/%b want=5/0", trial, done); end
        tick();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL t1_done got=%b/%b want=1/0", done, busy); end
        total++; if (result !== 3'd5 || steps !== 2'd3 || err !== 1'b0) begin bad++; $display("FAIL t1_result got=%0d/%0d/%b want=5/3/0", result, steps, err); end
        tick();
        total++; if (done !== 1'b0 || result !== 3'd5) begin bad++; $display("FAIL t1_hold got=%b/%0d want=0/5", done, result); end
    endtask

    task automatic test_t2_equal_first();
        int lat;
        do_search(3'd4, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL t2_latency got=%0d want=2", lat); end
        total++; if (result !== 3'd4 || steps !== 2'd1) begin bad++; $display("FAIL t2_result got=%0d/%0d want=4/1", result, steps); end
        tick();
    endtask

    task automatic test_t3_extremes();
        int lat;
        do_search(3'd0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL t3_lat0 got=%0d want=4", lat); end
        total++; if (result !== 3'd0 || steps !== 2'd3 || trial !== 3'd1) begin bad++; $display("FAIL t3_target0 got=%0d/%0d/%0d want=0/3/1", result, steps, trial); end
        tick();
        do_search(3'd7, lat);
        total++; if (result !== 3'd7 || steps !== 2'd3 || lat !== 4) begin bad++; $display("FAIL t3_target7 got=%0d/%0d/%0d want=7/3/4", result, steps, lat); end
        tick();
    endtask

    task automatic test_exhaustive();
        int exp_steps [8] = '{3, 3, 2, 3, 1, 3, 2, 3};
        for (int t = 0; t < 8; t++) begin
            int c;
            int bc;
            target = 3'(t);
            start  = 1'b1;
            tick();
            start  = 1'b0;
            c  = 1;
            bc = 0;
            while (!done && c < 20) begin
                start = (c == 1);   // stray start while busy must be ignored
                if (busy) bc++;
                tick();
                c++;
            end
            start = 1'b0;
            total++; if (result !== 3'(t)) begin bad++; $display("FAIL ex_result t=%0d got=%0d want=%0d", t, result, t); end
            total++; if (int'(steps) !== exp_steps[t] || c !== exp_steps[t] + 1) begin bad++; $display("FAIL ex_steps t=%0d got=%0d/%0d want=%0d/%0d", t, steps, c, exp_steps[t], exp_steps[t] + 1); end
            total++; if (bc !== exp_steps[t] || busy !== 1'b0) begin bad++; $display("FAIL ex_busy t=%0d got=%0d/%b want=%0d/0", t, bc, busy, exp_steps[t]); end
            tick();
        end
    endtask

    task automatic test_error_flags();
        int lat;
        target = 3'd5;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        force_none = 1'b1;
        tick();
        force_none = 1'b0;
        total++; if (done !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b/%b want=1/1", done, err); end
        total++; if (result !== 3'd6 || steps !== 2'd2 || busy !== 1'b0) begin bad++; $display("FAIL err_result got=%0d/%0d/%b want=6/2/0", result, steps, busy); end
        tick();
        total++; if (err !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL err_hold got=%b/%b want=1/0", err, done); end
        do_search(3'd5, lat);
        total++; if (err !== 1'b0 || result !== 3'd5 || lat !== 4) begin bad++; $display("FAIL err_clear got=%b/%0d/%0d want=0/5/4", err, result, lat); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw_done;
        target = 3'd5;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        total++; if ({trial, result, steps, busy, done, err} !== 11'd0) begin bad++; $display("FAIL rstmid_zero got=%0d/%0d/%0d/%b%b%b want=0", trial, result, steps, busy, done, err); end
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        total++; if (saw_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_nodone got=%b/%b want=0/0", saw_done, busy); end
        do_search(3'd3, lat);
        total++; if (result !== 3'd3 || steps !== 2'd3 || err !== 1'b0 || lat !== 4) begin bad++; $display("FAIL rstmid_clean got=%0d/%0d/%b/%0d want=3/3/0/4", result, steps, err, lat); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_search(3'd2, lat);
        total++; if (result !== 3'd2 || lat !== 3) begin bad++; $display("FAIL b2b_first got=%0d/%0d want=2/3", result, lat); end
        target = 3'd6;
        start  = 1'b1;   // asserted while done is high
        tick();
        start  = 1'b0;
        total++; if (busy !== 1'b1 || trial !== 3'd4 || done !== 1'b0) begin bad++; $display("FAIL b2b_restart got=%b/%0d/%b want=1/4/0", busy, trial, done); end
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        total++; if (result !== 3'd6 || steps !== 2'd2 || lat !== 3) begin bad++; $display("FAIL b2b_second got=%0d/%0d/%0d want=6/2/3", result, steps, lat); end
        tick();
    endtask

    initial begin
        test_reset();
        test_t1_target5();
        test_t2_equal_first();
        test_t3_extremes();
        test_exhaustive();
        test_error_flags();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
